// File: rtl/tri_loader_if.sv
// Triangle-load bus: DMA read channel toward host memory plus the
// beat-write channel toward the mem_triangle instances.
interface tri_loader_if;
   logic         dma_rd_req;
   logic [31:0]  dma_rd_addr;
   logic         dma_rd_gnt;
   logic         dma_rd_valid;
   logic [127:0] dma_rd_data;
   logic         we_MC;
   logic [127:0] data_MC;
   logic         done_MC;
   logic         rdy_MC;

   // Loader side
   modport master (
      output dma_rd_req,
      output dma_rd_addr,
      input  dma_rd_gnt,
      input  dma_rd_valid,
      input  dma_rd_data,
      output we_MC,
      output data_MC,
      output done_MC,
      input  rdy_MC
   );

   // DMA engine / triangle-memory side
   modport slave (
      input  dma_rd_req,
      input  dma_rd_addr,
      output dma_rd_gnt,
      output dma_rd_valid,
      output dma_rd_data,
      input  we_MC,
      input  data_MC,
      input  done_MC,
      output rdy_MC
   );
endinterface

// File: rtl/tri_loader.sv
// Triangle buffer loader: reads the scene's triangle beats from host memory
// over an in-order DMA read channel and streams them, one beat per cycle,
// into the triangle memories. A small response FIFO decouples the two sides;
// reads are only issued when the FIFO is guaranteed to have room for them.
module tri_loader #(
   parameter int unsigned NUM_TRI       = 512,
   parameter int unsigned BEATS_PER_TRI = 4,
   parameter int unsigned FIFO_DEPTH    = 8,
   localparam int unsigned BIT_TRI      = $clog2(NUM_TRI)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [31:0]       base_addr,
   input  logic [BIT_TRI:0]  num_tri,
   tri_loader_if.master      bus,
   output logic              busy,
   output logic              load_done,
   output logic              err_unexp
);

   localparam int unsigned TOT_MAX = NUM_TRI * BEATS_PER_TRI;
   localparam int unsigned TOT_W   = $clog2(TOT_MAX + 1);
   localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [1:0] {StIdle, StStream, StDone, StWaitRdy} state_t;

   state_t             state;
   logic [TOT_W-1:0]   total;
   logic [TOT_W-1:0]   req_cnt;
   logic [TOT_W-1:0]   wr_cnt;
   logic [31:0]        addr;
   logic [CNT_W-1:0]   outstanding;
   logic [CNT_W-1:0]   fifo_cnt;
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic               we_q;
   logic [127:0]       data_q;
   logic               done_q;
   logic               err_q;
   logic [127:0]       fifo_mem [FIFO_DEPTH];

   logic [BIT_TRI:0]   tri_clamp;
   logic [TOT_W-1:0]   total_next;
   logic [CNT_W:0]     credit_sum;
   logic               req;
   logic               grant;
   logic               unexp;
   logic               push;
   logic               fifo_empty;
   logic               pop;
   logic               push_to_mem;
   logic               pop_from_mem;
   logic [127:0]       pop_data;
   logic               start_ok;

   assign tri_clamp  = (num_tri > (BIT_TRI + 1)'(NUM_TRI)) ? (BIT_TRI + 1)'(NUM_TRI) : num_tri;
   assign total_next = TOT_W'(tri_clamp) * TOT_W'(BEATS_PER_TRI);
   assign start_ok   = start && (state == StIdle);

   // Request credit covers reads in flight plus beats already queued, so the
   // FIFO can never be overrun by returning data.
   assign credit_sum = {1'b0, outstanding} + {1'b0, fifo_cnt};
   assign req        = (state == StStream) && (req_cnt < total)
                       && (credit_sum < (CNT_W + 1)'(FIFO_DEPTH));
   assign grant      = req && bus.dma_rd_gnt;

   // Returning data with nothing in flight (e.g. from a load abandoned by
   // reset) is dropped rather than queued.
   assign unexp      = bus.dma_rd_valid && (outstanding == '0);
   assign push       = bus.dma_rd_valid && !unexp;
   assign fifo_empty = (fifo_cnt == '0);

   // An empty FIFO is bypassed so a beat arriving now is written next cycle.
   assign pop          = (state == StStream) && (!fifo_empty || push);
   assign pop_from_mem = pop && !fifo_empty;
   assign push_to_mem  = push && !(pop && fifo_empty);
   assign pop_data     = fifo_empty ? bus.dma_rd_data : fifo_mem[rd_ptr];

   assign bus.dma_rd_req  = req;
   assign bus.dma_rd_addr = addr;
   assign bus.we_MC       = we_q;
   assign bus.data_MC     = data_q;
   assign bus.done_MC     = done_q;
   assign busy            = (state != StIdle);
   assign load_done       = (state == StWaitRdy) && bus.rdy_MC;
   assign err_unexp       = err_q;

   // FIFO payload storage; validity is tracked by the pointers and count.
   always_ff @(posedge clk) begin
      if (push_to_mem) begin
         fifo_mem[wr_ptr] <= bus.dma_rd_data;
      end
   end

   // Control FSM, counters, FIFO bookkeeping and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= StIdle;
         total       <= '0;
         req_cnt     <= '0;
         wr_cnt      <= '0;
         addr        <= '0;
         outstanding <= '0;
         fifo_cnt    <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         we_q        <= 1'b0;
         data_q      <= '0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         we_q   <= pop;
         done_q <= (state == StDone);
         if (pop) begin
            data_q <= pop_data;
            wr_cnt <= wr_cnt + TOT_W'(1);
         end

         outstanding <= outstanding + CNT_W'(grant) - CNT_W'(push);
         fifo_cnt    <= fifo_cnt + CNT_W'(push) - CNT_W'(pop);
         if (push_to_mem) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop_from_mem) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end

         if (grant) begin
            addr    <= addr + 32'd16;
            req_cnt <= req_cnt + TOT_W'(1);
         end

         // A same-cycle unexpected return wins over the clear on start.
         if (start_ok) begin
            err_q <= 1'b0;
         end
         if (unexp) begin
            err_q <= 1'b1;
         end

         unique case (state)
            StIdle: begin
               if (start) begin
                  total   <= total_next;
                  addr    <= base_addr;
                  req_cnt <= '0;
                  wr_cnt  <= '0;
                  state   <= (total_next == '0) ? StDone : StStream;
               end
            end
            StStream: begin
               if (pop && (wr_cnt + TOT_W'(1) == total)) begin
                  state <= StDone;
               end
            end
            StDone: begin
               state <= StWaitRdy;
            end
            StWaitRdy: begin
               if (bus.rdy_MC) begin
                  state <= StIdle;
               end
            end
            default: begin
               state <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tri_loader.sv
// Bench for tri_loader: a DMA responder returns data derived from each
// address, and a per-cycle compare process checks requests, addresses,
// written beats and done timing against what the load should produce.
module tb_tri_loader;
   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [31:0] base_addr;
   logic [9:0]  num_tri;
   logic        busy;
   logic        load_done;
   logic        err_unexp;

   tri_loader_if bus ();

   tri_loader #(
      .NUM_TRI       (512),
      .BEATS_PER_TRI (4),
      .FIFO_DEPTH    (DEPTH)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .base_addr (base_addr),
      .num_tri   (num_tri),
      .bus       (bus),
      .busy      (busy),
      .load_done (load_done),
      .err_unexp (err_unexp)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;

   // Expected-load description, written by the stimulus
   int          exp_total = 0;
   logic [31:0] exp_base = '0;
   int          start_cyc = -100;
   int          load_id = 0;

   // Progress of the current load as observed by the compare process
   int           seen_id = 0;
   int           gnt_cnt = 0;
   int           wr_idx = 0;
   int           n_done = 0;
   int           last_we_cyc = -100;
   int           done_cyc = -100;
   logic [31:0]  last_addr = '0;
   logic [127:0] first_data = '0;

   // Responder controls
   bit gnt_en = 1'b1;
   bit valid_en = 1'b1;
   int lat = 2;
   typedef struct packed {logic [31:0] addr; int due;} rsp_t;
   rsp_t pend[$];

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [127:0] beat_data(input logic [31:0] a);
      return {a, a ^ 32'hA5A5_A5A5, ~a, a + 32'h0000_1234};
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // In-order DMA responder: grants when enabled, returns data lat cycles later.
   initial begin
      bus.dma_rd_gnt   = 1'b0;
      bus.dma_rd_valid = 1'b0;
      bus.dma_rd_data  = '0;
      forever begin
         @(posedge clk);
         #2;
         bus.dma_rd_valid = 1'b0;
         if (valid_en && pend.size() > 0 && pend[0].due <= cyc) begin
            bus.dma_rd_valid = 1'b1;
            bus.dma_rd_data  = beat_data(pend[0].addr);
            void'(pend.pop_front());
         end
         bus.dma_rd_gnt = bus.dma_rd_req && gnt_en;
         if (bus.dma_rd_gnt) pend.push_back('{addr: bus.dma_rd_addr, due: cyc + lat});
      end
   end

   // Every-cycle compare against the expected load.
   always @(negedge clk) begin
      bit exp_req;
      if (rst_n) begin
         if (load_id != seen_id) begin
            seen_id = load_id;
            gnt_cnt = 0;
            wr_idx = 0;
            n_done = 0;
            last_we_cyc = -100;
            done_cyc = -100;
         end
         if (bus.we_MC) begin
            if (wr_idx >= exp_total) chk("extra_beat", 1'b1, 1'b0);
            else chk("beat_data", bus.data_MC, beat_data(exp_base + 32'(16 * wr_idx)));
            if (wr_idx == 0) first_data = bus.data_MC;
            wr_idx++;
            last_we_cyc = cyc;
         end
         if (bus.done_MC) begin
            n_done++;
            done_cyc = cyc;
            chk("done_beats", wr_idx, exp_total);
            chk("done_time", cyc, (exp_total == 0) ? start_cyc + 2 : last_we_cyc + 1);
         end
         exp_req = (cyc > start_cyc) && (gnt_cnt < exp_total) && ((gnt_cnt - wr_idx) < DEPTH);
         chk("dma_rd_req", bus.dma_rd_req, exp_req);
         if (bus.dma_rd_req) chk("dma_rd_addr", bus.dma_rd_addr, exp_base + 32'(16 * gnt_cnt));
         if (bus.dma_rd_req && bus.dma_rd_gnt) begin
            last_addr = bus.dma_rd_addr;
            gnt_cnt++;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic run_load(input logic [31:0] base, input int nt);
      @(posedge clk);
      #1;
      base_addr = base;
      num_tri   = 10'(nt);
      start     = 1'b1;
      exp_base  = base;
      exp_total = ((nt > 512) ? 512 : nt) * 4;
      start_cyc = cyc;
      load_id++;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic finish_load(input int max_cyc);
      bit seen = 1'b0;
      for (int n = 0; n < max_cyc && !seen; n++) begin
         @(negedge clk);
         if (bus.done_MC) seen = 1'b1;
      end
      if (!seen) begin
         n_chk++;
         n_fail++;
         $display("FAIL done_timeout: no done_MC within %0d cycles, got 0 expected 1", max_cyc);
      end
      for (int n = 0; n < 2; n++) begin
         @(negedge clk);
         chk("wait_busy", busy, 1'b1);
         chk("wait_no_load_done", load_done, 1'b0);
      end
      @(posedge clk);
      #1;
      bus.rdy_MC = 1'b1;
      @(negedge clk);
      chk("load_done", load_done, 1'b1);
      chk("busy_at_load_done", busy, 1'b1);
      @(posedge clk);
      #1;
      bus.rdy_MC = 1'b0;
      @(negedge clk);
      chk("idle_busy", busy, 1'b0);
      chk("idle_load_done", load_done, 1'b0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst_n      = 1'b0;
      start      = 1'b0;
      base_addr  = '0;
      num_tri    = '0;
      bus.rdy_MC = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_req", bus.dma_rd_req, 1'b0);
      chk("rst_we", bus.we_MC, 1'b0);
      chk("rst_done", bus.done_MC, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_err", err_unexp, 1'b0);
      chk("rst_data", bus.data_MC, 128'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // One triangle, grant always, data two cycles after grant
      run_load(32'h0000_1000, 1);
      finish_load(100);
      chk("t1_beats", wr_idx, 4);
      chk("t1_last_addr", last_addr, 32'h0000_1030);
      chk("t1_first_data", first_data, 128'h00001000_A5A5B5A5_FFFFEFFF_00002234);
      chk("t1_done_latency", done_cyc - start_cyc, 8);
      chk("t1_done_count", n_done, 1);

      // Three triangles, grants withheld then returns stalled: credit limit
      gnt_en = 1'b0;
      valid_en = 1'b0;
      run_load(32'h0000_2000, 3);
      tick(9);
      gnt_en = 1'b1;
      tick(15);
      @(negedge clk);
      #1;
      chk("t2_stall_grants", gnt_cnt, 8);
      chk("t2_stall_req", bus.dma_rd_req, 1'b0);
      valid_en = 1'b1;
      finish_load(200);
      chk("t2_beats", wr_idx, 12);
      chk("t2_last_addr", last_addr, 32'h0000_20B0);

      // Zero triangles
      run_load(32'h0000_3000, 0);
      finish_load(20);
      chk("t3_beats", wr_idx, 0);
      chk("t3_grants", gnt_cnt, 0);
      chk("t3_done_latency", done_cyc - start_cyc, 2);
      chk("t3_done_count", n_done, 1);

      // Oversized count clamps to NUM_TRI
      run_load(32'h0002_0000, 600);
      finish_load(3000);
      chk("t4_beats", wr_idx, 2048);
      chk("t4_last_addr", last_addr, 32'h0002_7FF0);
      chk("t4_done_count", n_done, 1);

      // Reset in mid-stream with reads in flight, then late returns
      valid_en = 1'b0;
      run_load(32'h0000_8000, 2);
      tick(4);
      @(posedge clk);
      #1;
      exp_total = 0;
      load_id++;
      rst_n = 1'b0;
      @(negedge clk);
      chk("t5_rst_req", bus.dma_rd_req, 1'b0);
      chk("t5_rst_we", bus.we_MC, 1'b0);
      chk("t5_rst_done", bus.done_MC, 1'b0);
      chk("t5_rst_busy", busy, 1'b0);
      chk("t5_rst_data", bus.data_MC, 128'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      valid_en = 1'b1;
      for (int n = 0; n < 50 && pend.size() > 0; n++) tick(1);
      tick(2);
      @(negedge clk);
      chk("t5_pend_drained", pend.size(), 0);
      chk("t5_err_set", err_unexp, 1'b1);
      chk("t5_busy", busy, 1'b0);

      // Next start clears the error and loads cleanly
      run_load(32'h0000_1000, 1);
      @(negedge clk);
      chk("t6_err_cleared", err_unexp, 1'b0);
      finish_load(100);
      chk("t6_beats", wr_idx, 4);
      chk("t6_last_addr", last_addr, 32'h0000_1030);

      // Start while streaming is ignored
      run_load(32'h0000_4000, 2);
      tick(3);
      start = 1'b1;
      num_tri = 10'd5;
      base_addr = 32'h0000_9000;
      tick(1);
      start = 1'b0;
      finish_load(200);
      chk("t7_beats", wr_idx, 8);
      chk("t7_last_addr", last_addr, 32'h0000_4070);
      chk("t7_err", err_unexp, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
